// File: rtl/cu_seq.sv
// Multi-cycle control sequencer for the byte-serial CPU datapath: instruction fetch,
// operand read, execute with condition flags, write-back, and halt/run control.
module cu_seq #(
  parameter  int MAX_BYTES = 4,
  parameter  int NFLAGS    = 2,
  localparam int BW        = $clog2(MAX_BYTES),
  localparam int CW        = $clog2(NFLAGS + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic [BW-1:0]     i_ilen,
  input  logic              i_op_rd,
  input  logic              i_wb_reg,
  input  logic              i_wb_mem,
  input  logic              i_br,
  input  logic [CW-1:0]     i_br_cond,
  input  logic              i_halt_op,
  input  logic [NFLAGS-1:0] i_flag_upd,
  input  logic [NFLAGS-1:0] i_flags_in,
  input  logic              i_mem_rdy,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic              o_mem_addr_src,
  output logic              o_pc_en,
  output logic              o_pc_src,
  output logic              o_instr_we,
  output logic [BW-1:0]     o_instr_idx,
  output logic              o_op_we,
  output logic              o_reg_we,
  output logic [NFLAGS-1:0] o_flags,
  output logic              o_halted,
  output logic [2:0]        o_state_dbg
);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH0 = 3'd1,
    S_DECODE = 3'd2,
    S_FETCHN = 3'd3,
    S_OPRD   = 3'd4,
    S_EXEC   = 3'd5,
    S_WB     = 3'd6
  } state_t;

  state_t            r_state;
  logic [BW-1:0]     r_cnt;
  logic [NFLAGS-1:0] r_flags;
  logic              r_run_q;

  logic              w_run_rise;
  logic              w_cond_flag;
  logic              w_taken;
  logic              w_last_byte;
  state_t            w_after_fetch;
  state_t            w_boundary;

  assign w_run_rise    = i_run & ~r_run_q;
  assign w_last_byte   = (r_cnt == i_ilen);
  assign w_after_fetch = i_op_rd ? S_OPRD : S_EXEC;
  assign w_boundary    = i_run ? S_FETCH0 : S_HALT;

  // Condition codes above NFLAGS select no flag, so such branches are never taken.
  always_comb begin
    w_cond_flag = 1'b0;
    for (int k = 1; k <= NFLAGS; k++) begin
      if (i_br_cond == CW'(k)) w_cond_flag = r_flags[k-1];
    end
  end

  assign w_taken = i_br & ((i_br_cond == '0) | w_cond_flag);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_HALT;
      r_cnt   <= '0;
      r_flags <= '0;
      r_run_q <= 1'b0;
    end else begin
      r_run_q <= i_run;
      case (r_state)
        S_HALT: begin
          if (w_run_rise) r_state <= S_FETCH0;
        end
        S_FETCH0: begin
          if (i_mem_rdy) r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (i_ilen == '0) begin
            r_state <= w_after_fetch;
          end else begin
            r_state <= S_FETCHN;
            r_cnt   <= BW'(1);
          end
        end
        S_FETCHN: begin
          if (i_mem_rdy) begin
            if (w_last_byte) begin
              r_cnt   <= '0;
              r_state <= w_after_fetch;
            end else begin
              r_cnt <= r_cnt + BW'(1);
            end
          end
        end
        S_OPRD: begin
          if (i_mem_rdy) r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_flags <= (r_flags & ~i_flag_upd) | (i_flags_in & i_flag_upd);
          if (i_halt_op)                r_state <= S_HALT;
          else if (i_wb_reg | i_wb_mem) r_state <= S_WB;
          else                          r_state <= w_boundary;
        end
        S_WB: begin
          if (!i_wb_mem || i_mem_rdy) r_state <= w_boundary;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Strobes are decoded from the registered state so that a memory completion
  // (mem_rdy) acts in the same cycle and reset silences them immediately.
  always_comb begin
    o_mem_re       = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr_src = 1'b0;
    o_pc_en        = 1'b0;
    o_pc_src       = 1'b0;
    o_instr_we     = 1'b0;
    o_instr_idx    = '0;
    o_op_we        = 1'b0;
    o_reg_we       = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_FETCH0: begin
          o_mem_re   = 1'b1;
          o_instr_we = i_mem_rdy;
          o_pc_en    = i_mem_rdy;
        end
        S_FETCHN: begin
          o_mem_re    = 1'b1;
          o_instr_idx = r_cnt;
          o_instr_we  = i_mem_rdy;
          o_pc_en     = i_mem_rdy;
        end
        S_OPRD: begin
          o_mem_re       = 1'b1;
          o_mem_addr_src = 1'b1;
          o_op_we        = i_mem_rdy;
        end
        S_EXEC: begin
          o_pc_en  = w_taken;
          o_pc_src = w_taken;
        end
        S_WB: begin
          o_mem_we       = i_wb_mem;
          o_mem_addr_src = i_wb_mem;
          o_reg_we       = i_wb_reg & (~i_wb_mem | i_mem_rdy);
        end
        default: ;
      endcase
    end
  end

  assign o_flags     = r_flags;
  assign o_halted    = (r_state == S_HALT);
  assign o_state_dbg = r_state;

  a_one_mem_dir: assert property (@(posedge i_clk) !(o_mem_re && o_mem_we));

endmodule

// File: tb/tb_cu_seq.sv
// Bench for cu_seq: a transaction-level model predicts each cycle's outputs into a
// queue; a negedge monitor pops and compares against the DUT.
module tb_cu_seq;

  localparam int MAX_BYTES = 4;
  localparam int NFLAGS    = 2;

  logic       i_clk = 1'b0;
  logic       i_rst, i_run, i_op_rd, i_wb_reg, i_wb_mem, i_br, i_halt_op, i_mem_rdy;
  logic [1:0] i_ilen, i_br_cond, i_flag_upd, i_flags_in;
  logic       o_mem_re, o_mem_we, o_mem_addr_src, o_pc_en, o_pc_src, o_instr_we;
  logic       o_op_we, o_reg_we, o_halted;
  logic [1:0] o_instr_idx, o_flags;
  logic [2:0] o_state_dbg;

  cu_seq #(.MAX_BYTES(MAX_BYTES), .NFLAGS(NFLAGS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run), .i_ilen(i_ilen), .i_op_rd(i_op_rd),
    .i_wb_reg(i_wb_reg), .i_wb_mem(i_wb_mem), .i_br(i_br), .i_br_cond(i_br_cond),
    .i_halt_op(i_halt_op), .i_flag_upd(i_flag_upd), .i_flags_in(i_flags_in),
    .i_mem_rdy(i_mem_rdy), .o_mem_re(o_mem_re), .o_mem_we(o_mem_we),
    .o_mem_addr_src(o_mem_addr_src), .o_pc_en(o_pc_en), .o_pc_src(o_pc_src),
    .o_instr_we(o_instr_we), .o_instr_idx(o_instr_idx), .o_op_we(o_op_we),
    .o_reg_we(o_reg_we), .o_flags(o_flags), .o_halted(o_halted), .o_state_dbg(o_state_dbg)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  logic [15:0] exp_q[$];
  logic [1:0]  m_flags;
  int          checks = 0;
  int          errors = 0;

  // Expected output vector for one cycle; flags/halted come from the model state.
  function automatic logic [15:0] v(input logic re, we, asrc, pcen, pcsrc, iwe,
                                    input logic [1:0] idx, input logic opwe, regwe,
                                    input logic [2:0] st);
    return {re, we, asrc, pcen, pcsrc, iwe, idx, opwe, regwe, m_flags, (st == 3'd0), st};
  endfunction

  // Monitor
  always @(negedge i_clk) begin
    logic [15:0] got, e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {o_mem_re, o_mem_we, o_mem_addr_src, o_pc_en, o_pc_src, o_instr_we,
             o_instr_idx, o_op_we, o_reg_we, o_flags, o_halted, o_state_dbg};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cycle_vec t=%0t got=%h exp=%h (re,we,asrc,pcen,pcsrc,iwe,idx2,opwe,regwe,flags2,halted,st3)",
                 $time, got, e);
      end
    end
  end

  // Driver tasks: each call covers exactly one clock cycle, entered at posedge+1.
  task automatic cyc(input logic rdy, input logic [15:0] e);
    i_mem_rdy = rdy;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input logic [15:0] e);
    cyc(1'($urandom_range(0, 1)), e);
  endtask

  function automatic int wt(input int wfix);
    if (wfix >= 0) return wfix;
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  task automatic fetch(input logic [1:0] idx, input logic [2:0] st, input int w);
    repeat (w) cyc(1'b0, v(1, 0, 0, 0, 0, 0, idx, 0, 0, st));
    cyc(1'b1, v(1, 0, 0, 1, 0, 1, idx, 0, 0, st));
  endtask

  // One instruction, starting in FETCH0; returns after its last cycle.
  task automatic do_instr(input int ilen, input logic op_rd, wb_reg, wb_mem, br,
                          input int bc, input logic halt_op,
                          input logic [1:0] upd, fin, input int wfix);
    logic taken;
    int   w;
    i_ilen = 2'(ilen); i_op_rd = op_rd; i_wb_reg = wb_reg; i_wb_mem = wb_mem;
    i_br = br; i_br_cond = 2'(bc); i_halt_op = halt_op; i_flag_upd = upd; i_flags_in = fin;
    fetch(2'd0, 3'd1, wt(wfix));
    idle(v(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd2));
    for (int k = 1; k <= ilen; k++) fetch(2'(k), 3'd3, wt(wfix));
    if (op_rd) begin
      w = wt(wfix);
      repeat (w) cyc(1'b0, v(1, 0, 1, 0, 0, 0, 2'd0, 0, 0, 3'd4));
      cyc(1'b1, v(1, 0, 1, 0, 0, 0, 2'd0, 1, 0, 3'd4));
    end
    taken = br && (bc == 0 || (bc <= NFLAGS && m_flags[bc-1]));
    idle(v(0, 0, 0, taken, taken, 0, 2'd0, 0, 0, 3'd5));
    m_flags = (m_flags & ~upd) | (fin & upd);
    if (halt_op) return;
    if (wb_mem) begin
      w = wt(wfix);
      repeat (w) cyc(1'b0, v(0, 1, 1, 0, 0, 0, 2'd0, 0, 0, 3'd6));
      cyc(1'b1, v(0, 1, 1, 0, 0, 0, 2'd0, 0, wb_reg, 3'd6));
    end else if (wb_reg) begin
      idle(v(0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 3'd6));
    end
  endtask

  // From HALT: linger at the current run level, drop run, then raise it to restart.
  task automatic restart(input int hold);
    repeat (hold) idle(v(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0));
    i_run = 1'b0;
    repeat ($urandom_range(1, 2)) idle(v(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0));
    i_run = 1'b1;
    idle(v(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0));
  endtask

  initial begin
    logic hop;
    i_rst = 1'b1; i_run = 1'b1; i_mem_rdy = 1'b0; i_ilen = '0; i_op_rd = 1'b0;
    i_wb_reg = 1'b0; i_wb_mem = 1'b0; i_br = 1'b0; i_br_cond = '0; i_halt_op = 1'b0;
    i_flag_upd = '0; i_flags_in = '0;
    m_flags = '0;
    repeat (2) @(posedge i_clk);
    #1;
    // Reset with run held high: HALT for one cycle after release, then FETCH0.
    idle(v(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0));
    i_rst = 1'b0;
    idle(v(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0));

    repeat (3) do_instr(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    do_instr(3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2);

    // Flag/branch cases: same-cycle update is not seen, next instruction sees it.
    do_instr(0, 0, 0, 0, 1, 1, 0, 2'b01, 2'b01, 0);
    do_instr(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
    do_instr(0, 0, 0, 0, 1, 2, 0, 2'b00, 2'b00, 0);
    do_instr(0, 0, 0, 0, 1, 3, 0, 2'b00, 2'b00, 0);
    do_instr(1, 0, 1, 0, 1, 0, 0, 2'b11, 2'b10, 1);
    do_instr(0, 0, 0, 0, 1, 2, 0, 2'b00, 2'b00, 0);

    // Halt instruction with run still high.
    do_instr(0, 0, 1, 1, 0, 0, 1, 2'b11, 2'b11, 0);
    restart(3);

    // Reset while FETCHN waits on memory.
    i_ilen = 2'd2; i_op_rd = 1'b0; i_wb_reg = 1'b0; i_wb_mem = 1'b0; i_br = 1'b0;
    i_halt_op = 1'b0; i_flag_upd = '0; i_flags_in = '0;
    fetch(2'd0, 3'd1, 0);
    idle(v(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd2));
    cyc(1'b0, v(1, 0, 0, 0, 0, 0, 2'd1, 0, 0, 3'd3));
    i_rst = 1'b1;
    cyc(1'b0, v(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd3));
    m_flags = '0;
    i_rst = 1'b0;
    idle(v(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0));

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) i_run = 1'b0;
      hop = ($urandom_range(0, 11) == 0);
      do_instr(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), int'($urandom_range(0, 3)), hop,
               2'($urandom), 2'($urandom), -1);
      if (hop || !i_run) restart(int'($urandom_range(0, 2)));
    end

    @(negedge i_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
